// File: rtl/pin_check_pkg.sv
// Shared types and constants for the pin loopback checker.
// Latency: n/a (package only).
// Backpressure: n/a.
package pin_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Stimulus generator restarts from this value on every run.
    localparam logic [7:0] LFSR_SEED = 8'h01;

    // Taps for x^8+x^6+x^5+x^4+1 on a right-shifting register (feedback into bit 7).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // One right-shift step of the Fibonacci LFSR.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {^(s & LFSR_TAPS), s[7:1]};
    endfunction

endpackage

// File: rtl/pin_check_lfsr8.sv
// Seedable 8-bit Fibonacci LFSR; serial output is bit 0 of the current state.
// Latency: load/advance take effect on the next clock edge.
// Backpressure: none; advances only when adv_i is high, load_i has priority.
module pin_check_lfsr8
    import pin_check_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic adv_i,
    output logic bit_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Next state: reseed on load, otherwise shift when asked to advance.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = LFSR_SEED;
        end else if (adv_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // State register with synchronous reset to the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[0];

endmodule

// File: rtl/pin_loopback_checker.sv
// Drives LFSR bits to a pin under test, checks the looped-back (optionally inverted) bit and a tied pin.
// Latency: first compare LAT+1 cycles after accepted start; done num_vec+LAT+1 cycles after (1 if num_vec=0).
// Backpressure: none; start is ignored unless idle. Optional first-error capture: PIN_LOOPBACK_FIRST_ERR_EN.
module pin_loopback_checker
    import pin_check_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int LAT     = 2,   // legal 1..8
    parameter int INVERT  = 1,
    parameter int TIE_EXP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    output logic             drive_out,
    input  logic             loopback_in,
    input  logic             tied_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic             tie_err
`ifdef PIN_LOOPBACK_FIRST_ERR_EN
    ,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             first_err_vld
`endif
);

    localparam logic       INV_BIT    = (INVERT != 0);
    localparam logic       TIE_BIT    = (TIE_EXP != 0);
    localparam logic [2:0] DRAIN_LAST = 3'(LAT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       drain_q, drain_d;
    logic             drive_q, drive_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             tie_q, tie_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;

    // Expected-bit delay line; a valid tag marks slots that carry an issued vector.
    logic [LAT-1:0]   dly_bit_q;
    logic [LAT-1:0]   dly_vld_q;

    logic start_acc;
    logic issue;
    logic lfsr_bit;
    logic cmp_vld;
    logic mismatch;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign issue     = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign cmp_vld   = dly_vld_q[LAT-1];
    assign mismatch  = cmp_vld && (loopback_in != (dly_bit_q[LAT-1] ^ INV_BIT));

    pin_check_lfsr8 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (start_acc),
        .adv_i  (issue),
        .bit_o  (lfsr_bit)
    );

    // Run sequencing, error counting, tie monitoring and result reporting.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        drain_d = drain_q;
        drive_d = drive_q;
        err_d   = err_q;
        tie_d   = tie_q;
        pass_d  = pass_q;
        done_d  = 1'b0;

        if (mismatch && (err_q != '1)) begin
            err_d = err_q + 1'b1;
        end
        if (busy && (tied_in != TIE_BIT)) begin
            tie_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d   = num_vec;
                    err_d   = '0;
                    tie_d   = 1'b0;
                    pass_d  = 1'b0;
                    state_d = (num_vec == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                drive_d = lfsr_bit;
                rem_d   = rem_q - 1'b1;
                if (rem_q == CNT_W'(1)) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LAST;
                end
            end
            ST_DRAIN: begin
                // drive_out holds; wait until the last issued bit has been compared.
                if (drain_q == 3'd0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            ST_DONE: begin
                // err_q already includes the final compare made on the DRAIN exit edge.
                done_d  = 1'b1;
                pass_d  = (err_q == '0) && !tie_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            drain_q <= 3'd0;
            drive_q <= 1'b0;
            err_q   <= '0;
            tie_q   <= 1'b0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            drain_q <= drain_d;
            drive_q <= drive_d;
            err_q   <= err_d;
            tie_q   <= tie_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    // Expected-bit pipeline: each issued bit travels LAT stages alongside the pin loop.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            dly_bit_q <= '0;
            dly_vld_q <= '0;
        end else begin
            dly_bit_q[0] <= lfsr_bit;
            dly_vld_q[0] <= issue;
            for (int i = 1; i < LAT; i++) begin
                dly_bit_q[i] <= dly_bit_q[i-1];
                dly_vld_q[i] <= dly_vld_q[i-1];
            end
        end
    end

    assign drive_out = drive_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_q;
    assign tie_err   = tie_q;

`ifdef PIN_LOOPBACK_FIRST_ERR_EN
    logic [CNT_W-1:0] cmp_idx_q;
    logic [CNT_W-1:0] fe_idx_q;
    logic             fe_vld_q;

    // Count compares to know each vector's index; latch the index of the first miss.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            cmp_idx_q <= '0;
            fe_idx_q  <= '0;
            fe_vld_q  <= 1'b0;
        end else begin
            if (cmp_vld) begin
                cmp_idx_q <= cmp_idx_q + 1'b1;
            end
            if (mismatch && !fe_vld_q) begin
                fe_idx_q <= cmp_idx_q;
                fe_vld_q <= 1'b1;
            end
        end
    end

    assign first_err_idx = fe_idx_q;
    assign first_err_vld = fe_vld_q;
`endif

endmodule

// File: tb/tb_pin_loopback_checker.sv
// Self-checking bench for pin_loopback_checker with a behavioural pin-loop model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pin_loopback_checker;

    localparam int   CNT_W   = 16;
    localparam int   LAT     = 2;
    localparam int   INVERT  = 1;
    localparam int   TIE_EXP = 1;
    localparam logic INV_BIT = (INVERT != 0);
    localparam logic TIE_BIT = (TIE_EXP != 0);
    localparam int   NONE    = -1000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             drive_out;
    logic             loopback_in;
    logic             tied_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic             tie_err;
`ifdef PIN_LOOPBACK_FIRST_ERR_EN
    logic [CNT_W-1:0] first_err_idx;
    logic             first_err_vld;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pin_loopback_checker #(
        .CNT_W   (CNT_W),
        .LAT     (LAT),
        .INVERT  (INVERT),
        .TIE_EXP (TIE_EXP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_vec     (num_vec),
        .drive_out   (drive_out),
        .loopback_in (loopback_in),
        .tied_in     (tied_in),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_cnt     (err_cnt),
        .tie_err     (tie_err)
`ifdef PIN_LOOPBACK_FIRST_ERR_EN
        ,
        .first_err_idx (first_err_idx),
        .first_err_vld (first_err_vld)
`endif
    );

    // Reference stimulus: x^8+x^6+x^5+x^4+1, right shift, parity of the tapped bits enters at bit 7.
    function automatic logic [7:0] model_step(input logic [7:0] s);
        int fb;
        fb = $countones(s & 8'hB8) % 2;
        return (s >> 1) | 8'(fb << 7);
    endfunction

    // Runs one test vector set. Cycle c counts edges after the start edge (start edge is c=0).
    // The pin loop is modelled so the bit driven after edge j+1 is the one sampled at edge j+1+LAT.
    task automatic do_run(input int n, input int bad_a, input int bad_b, input int tie_cyc,
                          input bit spam, output int done_lat, output int drv_bad,
                          output int done_cnt, output int busy_bad);
        logic [7:0] s;
        logic       exp_bits[$];
        logic       hist[$];
        logic       lb;
        logic       exp_busy;
        s = 8'h01;
        for (int j = 0; j < n; j++) begin
            exp_bits.push_back(s[0]);
            s = model_step(s);
        end
        done_lat = -1;
        drv_bad  = 0;
        done_cnt = 0;
        busy_bad = 0;
        num_vec  = CNT_W'(n);
        start    = 1'b1;
        for (int c = 0; c <= n + LAT + 10; c++) begin
            @(posedge clk);
            #1;
            start   = 1'b0;
            tied_in = (c == tie_cyc) ? !TIE_BIT : TIE_BIT;
            if (c >= 1 && c <= n && drive_out !== exp_bits[c-1]) drv_bad++;
            if (n > 0 && c > n && c <= n + LAT && drive_out !== exp_bits[n-1]) drv_bad++;
            exp_busy = (n > 0 && c <= n + LAT - 1);
            if (busy !== exp_busy) busy_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_lat < 0) done_lat = c;
            end
            if (spam && n > 0 && c < n) start = 1'($urandom_range(0, 1));
            if (spam && n > 0 && c == n + LAT) start = 1'b1;  // lands while in DONE
            hist.push_back(drive_out);
            if (hist.size() > LAT) void'(hist.pop_front());
            lb = (hist.size() == LAT) ? hist[0] : 1'b0;
            lb = lb ^ INV_BIT;
            if ((c - LAT) >= 0 && ((c - LAT) == bad_a || (c - LAT) == bad_b)) lb = !lb;
            loopback_in = lb;
        end
        tied_in = TIE_BIT;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (drive_out !== 1'b0) begin errors++; $display("FAIL reset_drive got %b exp 0", drive_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b exp 0", pass); end
        checks++; if (err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
        checks++; if (tie_err !== 1'b0) begin errors++; $display("FAIL reset_tie_err got %b exp 0", tie_err); end
    endtask

    task automatic test_num_vec_zero();
        int dl, db, dc, bb;
        do_run(0, NONE, NONE, NONE, 1'b0, dl, db, dc, bb);
        checks++; if (dl !== 1) begin errors++; $display("FAIL zero_done_lat got %0d exp 1", dl); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL zero_done_count got %0d exp 1", dc); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL zero_pass got %b exp 1", pass); end
        checks++; if (drive_out !== 1'b0) begin errors++; $display("FAIL zero_drive got %b exp 0", drive_out); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL zero_busy got %0d bad cycles exp 0", bb); end
    endtask

    task automatic test_ideal();
        int dl, db, dc, bb;
        do_run(100, NONE, NONE, NONE, 1'b0, dl, db, dc, bb);
        checks++; if (dl !== 100 + LAT + 1) begin errors++; $display("FAIL ideal_done_lat got %0d exp %0d", dl, 100 + LAT + 1); end
        checks++; if (db !== 0) begin errors++; $display("FAIL ideal_drive_seq got %0d bad bits exp 0", db); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL ideal_busy got %0d bad cycles exp 0", bb); end
        checks++; if (err_cnt !== '0) begin errors++; $display("FAIL ideal_err_cnt got %0d exp 0", err_cnt); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL ideal_pass got %b exp 1", pass); end
        checks++; if (tie_err !== 1'b0) begin errors++; $display("FAIL ideal_tie_err got %b exp 0", tie_err); end
    endtask

    task automatic test_errors();
        int dl, db, dc, bb;
        do_run(100, 10, 57, NONE, 1'b0, dl, db, dc, bb);
        checks++; if (err_cnt !== CNT_W'(2)) begin errors++; $display("FAIL errors_err_cnt got %0d exp 2", err_cnt); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL errors_pass got %b exp 0", pass); end
        checks++; if (dl !== 100 + LAT + 1) begin errors++; $display("FAIL errors_done_lat got %0d exp %0d", dl, 100 + LAT + 1); end
`ifdef PIN_LOOPBACK_FIRST_ERR_EN
        checks++; if (first_err_vld !== 1'b1) begin errors++; $display("FAIL errors_first_vld got %b exp 1", first_err_vld); end
        checks++; if (first_err_idx !== CNT_W'(10)) begin errors++; $display("FAIL errors_first_idx got %0d exp 10", first_err_idx); end
`endif
    endtask

    task automatic test_tie();
        int dl, db, dc, bb;
        do_run(20, NONE, NONE, 9, 1'b0, dl, db, dc, bb);
        checks++; if (tie_err !== 1'b1) begin errors++; $display("FAIL tie_tie_err got %b exp 1", tie_err); end
        checks++; if (err_cnt !== '0) begin errors++; $display("FAIL tie_err_cnt got %0d exp 0", err_cnt); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL tie_pass got %b exp 0", pass); end
    endtask

    task automatic test_mid_reset();
        int dl, db, dc, bb;
        num_vec = CNT_W'(50);
        start   = 1'b1;
        tied_in = !TIE_BIT;
        repeat (5) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        checks++; if (busy !== 1'b1 || tie_err !== 1'b1) begin errors++; $display("FAIL midrst_pre busy=%b tie_err=%b exp 1 1", busy, tie_err); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        tied_in = TIE_BIT;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || drive_out !== 1'b0)
            begin errors++; $display("FAIL midrst_ctrl busy=%b done=%b pass=%b drive=%b exp 0 0 0 0", busy, done, pass, drive_out); end
        checks++; if (err_cnt !== '0 || tie_err !== 1'b0)
            begin errors++; $display("FAIL midrst_status err_cnt=%0d tie_err=%b exp 0 0", err_cnt, tie_err); end
        do_run(8, NONE, NONE, NONE, 1'b0, dl, db, dc, bb);
        checks++; if (dl !== 8 + LAT + 1 || pass !== 1'b1)
            begin errors++; $display("FAIL midrst_rerun done_lat=%0d pass=%b exp %0d 1", dl, pass, 8 + LAT + 1); end
    endtask

    task automatic test_back_to_back();
        int dl, db, dc, bb;
        do_run(30, NONE, NONE, NONE, 1'b1, dl, db, dc, bb);
        checks++; if (dc !== 1) begin errors++; $display("FAIL spam_done_count got %0d exp 1", dc); end
        checks++; if (dl !== 30 + LAT + 1) begin errors++; $display("FAIL spam_done_lat got %0d exp %0d", dl, 30 + LAT + 1); end
        checks++; if (err_cnt !== '0 || pass !== 1'b1) begin errors++; $display("FAIL spam_result err_cnt=%0d pass=%b exp 0 1", err_cnt, pass); end
        checks++; if (db !== 0 || bb !== 0) begin errors++; $display("FAIL spam_seq drive_bad=%0d busy_bad=%0d exp 0 0", db, bb); end
    endtask

    task automatic test_random();
        int dl, db, dc, bb, n, ba, bc, exp_err;
        for (int it = 0; it < 8; it++) begin
            n  = int'($urandom_range(1, 60));
            ba = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : NONE;
            bc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : NONE;
            exp_err = 0;
            if (ba >= 0) exp_err++;
            if (bc >= 0 && bc != ba) exp_err++;
            do_run(n, ba, bc, NONE, 1'b0, dl, db, dc, bb);
            checks++; if (dl !== n + LAT + 1) begin errors++; $display("FAIL rand%0d_done_lat got %0d exp %0d", it, dl, n + LAT + 1); end
            checks++; if (err_cnt !== CNT_W'(exp_err)) begin errors++; $display("FAIL rand%0d_err_cnt got %0d exp %0d", it, err_cnt, exp_err); end
            checks++; if (pass !== (exp_err == 0)) begin errors++; $display("FAIL rand%0d_pass got %b exp %b", it, pass, (exp_err == 0)); end
            checks++; if (db !== 0) begin errors++; $display("FAIL rand%0d_drive_seq got %0d bad bits exp 0", it, db); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        num_vec     = '0;
        loopback_in = 1'b0;
        tied_in     = TIE_BIT;
        test_reset();
        test_num_vec_zero();
        test_ideal();
        test_errors();
        test_tie();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
